l3_arbiter: RTL and testbench

//  Round-robin arbiter sharing one L3 memory port between N_CORE cores.

---
 rtl/l3_arbiter_pkg.sv | 15 +
 rtl/l3_arbiter_if.sv | 30 +++
 rtl/l3_arbiter_rr_pick.sv | 21 ++
 rtl/l3_arbiter.sv | 123 ++++++++++++
 tb/tb_l3_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/l3_arbiter_pkg.sv
// l3_arbiter_pkg: shared FSM encodings, default widths and index-width helper
package l3_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;
  localparam int DEF_N_CORE  = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_TMO_CYC = 63;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/l3_arbiter_if.sv
// l3_arbiter_if: core request/grant bundle plus the single L3 memory port
interface l3_arbiter_if import l3_arbiter_pkg::*; #(
  parameter int N_CORE = DEF_N_CORE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [N_CORE-1:0]        req;
  logic [N_CORE-1:0]        req_we;
  logic [N_CORE*ADDR_W-1:0] req_addr;
  logic [N_CORE*DATA_W-1:0] req_wdata;
  logic [N_CORE-1:0]        gnt;
  logic [N_CORE-1:0]        ack;
  logic                     err;
  logic [DATA_W-1:0]        rdata;
  logic                     busy;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_rdy;
  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata, mem_rdy,
    output gnt, ack, err, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata, mem_rdy,
    input  gnt, ack, err, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l3_arbiter_rr_pick.sv
// rr_pick: round-robin selection of the first requester after the last grant
module rr_pick import l3_arbiter_pkg::*; #(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] pick,
  output logic         valid
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = req[W'((int'(last) + 1 + i) % N)];
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
    pick  = W'((int'(last) + 1 + int'(off)) % N);
    valid = |req;
  end
endmodule

// File: rtl/l3_arbiter.sv
// l3_arbiter: round-robin sharing of one L3 port between N_CORE cores
// One transaction at a time: IDLE grants and latches, ACCESS waits for mem_rdy or timeout, DONE acks.
module l3_arbiter import l3_arbiter_pkg::*; #(
  parameter int N_CORE  = DEF_N_CORE,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input logic          CLK,
  input logic          RESET,
  l3_arbiter_if.slave  bus
);
  localparam int LW = idx_w(N_CORE);
  localparam int CW = idx_w(TMO_CYC + 1);
  localparam logic [N_CORE-1:0] ONE = 1;
  arb_state_t        state_q, state_d;
  logic [N_CORE-1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic              err_q, err_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]     last_q, last_d, pick;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pick_valid, slot_we;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;
  rr_pick #(.N(N_CORE), .W(LW)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );
  always_comb begin
    slot_we    = 1'b0;
    slot_addr  = '0;
    slot_wdata = '0;
    for (int i = 0; i < N_CORE; i++) begin
      if (int'(pick) == i) begin
        slot_we    = bus.req_we[i];
        slot_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        slot_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = ack_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    case (state_q)
      ARB_IDLE: if (pick_valid) begin
        gnt_d       = ONE << pick;
        last_d      = pick;
        mem_en_d    = 1'b1;
        mem_we_d    = slot_we;
        mem_addr_d  = slot_addr;
        mem_wdata_d = slot_wdata;
        cnt_d       = '0;
        state_d     = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        cnt_d = bus.mem_rdy ? cnt_q : cnt_q + CW'(1);
        // mem_rdy wins over a timeout landing on the same cycle
        if (bus.mem_rdy || cnt_q == CW'(TMO_CYC - 1)) begin
          mem_en_d = 1'b0;
          ack_d    = gnt_q;
          err_d    = !bus.mem_rdy;
          rdata_d  = (bus.mem_rdy && !mem_we_q) ? bus.mem_rdata : rdata_q;
          state_d  = ARB_DONE;
        end
      end
      ARB_DONE: begin
        gnt_d   = '0;
        ack_d   = '0;
        err_d   = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      last_q      <= LW'(N_CORE - 1);
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != ARB_IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_l3_arbiter.sv
// tb_l3_arbiter: directed bench with a scoreboard of expected acks and grant order
module tb_l3_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int TMO = 63;
  typedef struct {
    int            core;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  exp_t sb[$];
  int gq[$];
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_rd = '0;
  always #5 CLK = ~CLK;
  l3_arbiter_if #(.N_CORE(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
  l3_arbiter #(.N_CORE(N), .DATA_W(DW), .ADDR_W(AW), .TMO_CYC(TMO)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_slot(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_we[c] = we;
    bus.req_addr[c*AW +: AW] = a;
    bus.req_wdata[c*DW +: DW] = d;
  endtask
  task automatic wait_gnt();
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      ok = |bus.gnt;
    end
    chk("gnt_seen", 32'(ok), 32'd1);
  endtask
  task automatic txn(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input int dly, input logic [DW-1:0] md, input bit tmo);
    int   n = 0;
    exp_t e;
    set_slot(c, we, a, wd);
    bus.req[c] = 1'b1;
    sb.push_back('{c, (we || tmo) ? last_rd : md, tmo});
    wait_gnt();
    chk("gnt", 32'(bus.gnt), 32'(1 << c));
    chk("mem_en", 32'(bus.mem_en), 32'd1);
    chk("mem_we", 32'(bus.mem_we), 32'(we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(a));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
    chk("busy", 32'(bus.busy), 32'd1);
    // the granted slot changes mid-access; the latched transaction must not follow it
    set_slot(c, ~we, ~a, ~wd);
    if (!tmo) begin
      repeat (dly - 1) @(negedge CLK);
      chk("hold_addr", 32'(bus.mem_addr), 32'(a));
      chk("hold_wdata", 32'(bus.mem_wdata), 32'(wd));
      chk("hold_we", 32'(bus.mem_we), 32'(we));
      chk("hold_en", 32'(bus.mem_en), 32'd1);
      bus.mem_rdy = 1'b1;
      bus.mem_rdata = md;
    end
    while (!(|bus.ack) && n < TMO + 10) begin
      @(negedge CLK);
      bus.mem_rdy = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      n++;
    end
    chk("ack_seen", 32'(|bus.ack), 32'd1);
    if (tmo) chk("tmo_cycles", 32'(n), 32'(TMO));
    e = sb.pop_front();
    chk("ack", 32'(bus.ack), 32'(1 << e.core));
    chk("err", 32'(bus.err), 32'(e.err));
    chk("rdata", 32'(bus.rdata), 32'(e.rdata));
    chk("gnt_hold", 32'(bus.gnt), 32'(1 << e.core));
    chk("mem_en_low", 32'(bus.mem_en), 32'd0);
    if (!we && !tmo) last_rd = md;
    bus.req[c] = 1'b0;
    @(negedge CLK);
    chk("ack_pulse", 32'(bus.ack), 32'd0);
    chk("gnt_clear", 32'(bus.gnt), 32'd0);
    chk("err_clear", 32'(bus.err), 32'd0);
    chk("idle", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int g;
    int prev;
    bus.req = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_rdy = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge CLK);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    txn(2, 1'b0, 16'h0040, 16'h0000, 2, 16'hBEEF, 1'b0);
    txn(1, 1'b1, 16'h00FF, 16'h1234, 3, 16'hDEAD, 1'b0);
    bus.mem_rdy = 1'b1;
    bus.mem_rdata = 16'h5555;
    repeat (3) @(negedge CLK);
    chk("idle_rdy_busy", 32'(bus.busy), 32'd0);
    chk("idle_rdy_ack", 32'(bus.ack), 32'd0);
    chk("idle_rdy_rdata", 32'(bus.rdata), 32'(last_rd));
    chk("idle_rdy_en", 32'(bus.mem_en), 32'd0);
    bus.mem_rdy = 1'b0;
    txn(3, 1'b0, 16'h0100, 16'h0000, 1, 16'h0000, 1'b1);
    for (int i = 0; i < N; i++) set_slot(i, 1'b0, AW'(i * 16), '0);
    gq = '{0, 1, 2, 3, 0};
    prev = -1;
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      g = -1;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) g = i;
      chk("rr_order", 32'(g), 32'(gq.pop_front()));
      chk("rr_no_repeat", 32'(g != prev), 32'd1);
      prev = g;
      bus.mem_rdy = 1'b1;
      bus.mem_rdata = DW'(16'hA000 + k);
      @(negedge CLK);
      bus.mem_rdy = 1'b0;
      chk("rr_ack", 32'(bus.ack), 32'(1 << g));
      chk("rr_rdata", 32'(bus.rdata), 32'(16'hA000 + k));
      last_rd = DW'(16'hA000 + k);
      if (g >= 0) bus.req[g] = 1'b0;
      @(negedge CLK);
      chk("rr_ack_pulse", 32'(bus.ack), 32'd0);
      if (g >= 0 && k < 4) bus.req[g] = 1'b1;
    end
    bus.req = '0;
    @(negedge CLK);
    set_slot(3, 1'b1, 16'h0333, 16'h3333);
    bus.req[3] = 1'b1;
    wait_gnt();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h8);
    chk("pre_rst_en", 32'(bus.mem_en), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_en", 32'(bus.mem_en), 32'd0);
    chk("async_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_rdata", 32'(bus.rdata), 32'd0);
    bus.req = '0;
    last_rd = '0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    txn(0, 1'b0, 16'h0ABC, 16'h0000, 1, 16'h7777, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
